// File: rtl/writeback_unit.sv
// In-order writeback queue: pairs issued tokens with results in order, drives the register
// file write port one retirement per cycle, and flags registers with writes still in flight.
module writeback_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [4:0]               issue_rd,
    input  logic                     issue_reg_write,
    input  logic                     result_valid,
    output logic                     result_ready,
    input  logic [XLEN-1:0]          result_data,
    output logic [4:0]               reg_write_dest,
    output logic                     need_to_write,
    output logic [XLEN-1:0]          reg_write_dest_value,
    input  logic [4:0]               rs1_query,
    input  logic [4:0]               rs2_query,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] OccFull = (PW+1)'(DEPTH);

    logic [4:0]      r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_we;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_done;

    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [PW-1:0]   r_res;
    logic [PW:0]     r_occ;

    logic            r_nw;
    logic [4:0]      r_dest;
    logic [XLEN-1:0] r_val;

    logic w_issue_ready;
    logic w_result_ready;
    logic w_issue;
    logic w_result;
    logic w_retire;
    logic w_rs1_hit;
    logic w_rs2_hit;

    always_comb begin
        w_issue_ready  = (r_occ != OccFull);
        // res equals tail once every entry has its result, and that slot is never valid-but-not-done
        w_result_ready = r_valid[r_res] && !r_done[r_res];
        w_issue        = issue_valid && w_issue_ready;
        w_result       = result_valid && w_result_ready;
        w_retire       = r_valid[r_head] && r_done[r_head];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_res   <= '0;
            r_occ   <= '0;
            r_valid <= '0;
            r_done  <= '0;
            r_nw    <= 1'b0;
            r_dest  <= '0;
            r_val   <= '0;
        end else begin
            if (w_issue) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_result) begin
                r_done[r_res] <= 1'b1;
                r_res         <= r_res + PW'(1);
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + PW'(1);
                r_dest          <= r_rd[r_head];
                r_val           <= r_data[r_head];
                r_nw            <= r_we[r_head] && (r_rd[r_head] != 5'd0);
            end else begin
                r_nw <= 1'b0;
            end
            r_occ <= r_occ + (PW+1)'(w_issue) - (PW+1)'(w_retire);
        end
    end

    // Payload needs no reset: valid/done gate every use of it.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rd[r_tail] <= issue_rd;
            r_we[r_tail] <= issue_reg_write;
        end
        if (w_result) begin
            r_data[r_res] <= result_data;
        end
    end

    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && r_we[i] && (r_rd[i] == rs1_query)) w_rs1_hit = 1'b1;
            if (r_valid[i] && r_we[i] && (r_rd[i] == rs2_query)) w_rs2_hit = 1'b1;
        end
    end

    // The output stage still counts: the register file commits at the end of that cycle.
    assign rs1_busy = (rs1_query != 5'd0) && (w_rs1_hit || (r_nw && (r_dest == rs1_query)));
    assign rs2_busy = (rs2_query != 5'd0) && (w_rs2_hit || (r_nw && (r_dest == rs2_query)));

    assign issue_ready          = w_issue_ready;
    assign result_ready         = w_result_ready;
    assign occupancy            = r_occ;
    assign need_to_write        = r_nw;
    assign reg_write_dest       = r_dest;
    assign reg_write_dest_value = r_val;

endmodule
